// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared defaults, error codes and saturation value for the parking tracker
package parking_pkg;

  localparam int TIME_W_DEF = 8;
  localparam int SLOTS_DEF  = 4;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OCCUPIED = 2'd1,
    ERR_EMPTY    = 2'd2,
    ERR_RANGE    = 2'd3
  } err_code_e;

  localparam logic [TIME_W_DEF-1:0] DUR_SAT = '1;

endpackage

// File: rtl/time_sub_w.sv
// rtl/time_sub_w.sv - W-bit modular subtractor a - b as a ripple of full adders on ~b with carry-in 1
module time_sub_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  logic [W-1:0] b_n;
  logic [W-1:0] carry;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  genvar i;
  for (i = 0; i < W; i++) begin : g_fa
    assign diff[i] = a[i] ^ b_n[i] ^ carry[i];
    // The carry out of the top bit is the borrow, which modular time ignores.
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
    end
  end

endmodule

// File: rtl/parking_duration_tracker.sv
// rtl/parking_duration_tracker.sv - per-slot entry stamps, lap detection and registered stay durations
module parking_duration_tracker
  import parking_pkg::*;
#(
  parameter  int TIME_W = TIME_W_DEF,
  parameter  int SLOTS  = SLOTS_DEF,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enter_valid,
  input  logic [SLOT_W-1:0] enter_slot,
  input  logic              exit_valid,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              out_valid,
  output logic [SLOT_W-1:0] out_slot,
  output logic [TIME_W-1:0] out_duration,
  output logic              out_overflow,
  output logic              err_enter,
  output logic              err_exit,
  output logic [SLOTS-1:0]  occupied,
  output logic [TIME_W-1:0] now
);

  logic [TIME_W-1:0]             now_q, now_d, now_inc;
  logic [SLOTS-1:0]              occ_q, occ_d;
  logic [SLOTS-1:0]              lap_q, lap_d;
  logic [SLOTS-1:0][TIME_W-1:0]  stamp_q, stamp_d;
  logic                          out_valid_q, out_valid_d;
  logic [SLOT_W-1:0]             out_slot_q, out_slot_d;
  logic [TIME_W-1:0]             out_duration_q, out_duration_d;
  logic                          out_overflow_q, out_overflow_d;
  logic                          err_enter_q, err_enter_d;
  logic                          err_exit_q, err_exit_d;

  logic                          enter_legal, exit_legal;
  logic                          enter_ok, exit_ok, enter_busy;
  err_code_e                     enter_code, exit_code;
  logic [TIME_W-1:0]             stamp_sel, diff;

  if (SLOTS == (1 << SLOT_W)) begin : g_full_range
    assign enter_legal = 1'b1;
    assign exit_legal  = 1'b1;
  end else begin : g_part_range
    assign enter_legal = 32'(enter_slot) < SLOTS;
    assign exit_legal  = 32'(exit_slot) < SLOTS;
  end

  assign now_inc   = now_q + TIME_W'(1);
  assign stamp_sel = exit_legal ? stamp_q[exit_slot] : '0;

  time_sub_w #(.W(TIME_W)) u_sub (
    .a    (now_q),
    .b    (stamp_sel),
    .diff (diff)
  );

  // Exit is judged first so a same-slot entry sees the slot as already vacated.
  always_comb begin
    exit_code = ERR_NONE;
    if (exit_valid) begin
      if (!exit_legal)             exit_code = ERR_RANGE;
      else if (!occ_q[exit_slot])  exit_code = ERR_EMPTY;
    end
    exit_ok = exit_valid && (exit_code == ERR_NONE);

    enter_busy = 1'b0;
    if (enter_legal) begin
      enter_busy = occ_q[enter_slot] && !(exit_ok && (exit_slot == enter_slot));
    end
    enter_code = ERR_NONE;
    if (enter_valid) begin
      if (!enter_legal)    enter_code = ERR_RANGE;
      else if (enter_busy) enter_code = ERR_OCCUPIED;
    end
    enter_ok = enter_valid && (enter_code == ERR_NONE);
  end

  always_comb begin
    now_d          = tick ? now_inc : now_q;
    occ_d          = occ_q;
    lap_d          = lap_q;
    stamp_d        = stamp_q;
    out_valid_d    = exit_ok;
    out_slot_d     = out_slot_q;
    out_duration_d = out_duration_q;
    out_overflow_d = out_overflow_q;
    err_enter_d    = (enter_code != ERR_NONE);
    err_exit_d     = (exit_code != ERR_NONE);

    // Time base coming back round to the stamp means the stay has covered a full lap.
    for (int s = 0; s < SLOTS; s++) begin
      if (tick && occ_q[s] && (now_inc == stamp_q[s])) lap_d[s] = 1'b1;
    end

    if (exit_ok) begin
      out_slot_d         = exit_slot;
      out_duration_d     = lap_q[exit_slot] ? {TIME_W{1'b1}} : diff;
      out_overflow_d     = lap_q[exit_slot];
      occ_d[exit_slot]   = 1'b0;
      lap_d[exit_slot]   = 1'b0;
    end

    if (enter_ok) begin
      stamp_d[enter_slot] = now_q;
      occ_d[enter_slot]   = 1'b1;
      lap_d[enter_slot]   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q          <= '0;
      occ_q          <= '0;
      lap_q          <= '0;
      stamp_q        <= '0;
      out_valid_q    <= 1'b0;
      out_slot_q     <= '0;
      out_duration_q <= '0;
      out_overflow_q <= 1'b0;
      err_enter_q    <= 1'b0;
      err_exit_q     <= 1'b0;
    end else begin
      now_q          <= now_d;
      occ_q          <= occ_d;
      lap_q          <= lap_d;
      stamp_q        <= stamp_d;
      out_valid_q    <= out_valid_d;
      out_slot_q     <= out_slot_d;
      out_duration_q <= out_duration_d;
      out_overflow_q <= out_overflow_d;
      err_enter_q    <= err_enter_d;
      err_exit_q     <= err_exit_d;
    end
  end

  assign now          = now_q;
  assign occupied     = occ_q;
  assign out_valid    = out_valid_q;
  assign out_slot     = out_slot_q;
  assign out_duration = out_duration_q;
  assign out_overflow = out_overflow_q;
  assign err_enter    = err_enter_q;
  assign err_exit     = err_exit_q;

endmodule

// File: tb/tb_parking_duration_tracker.sv
// tb/tb_parking_duration_tracker.sv - randomized and directed bench against an absolute-time stay model
module tb_parking_duration_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, enter_valid = 1'b0, exit_valid = 1'b0;
  logic [1:0] enter_slot = '0, exit_slot = '0;
  logic       out_valid, out_overflow, err_enter, err_exit;
  logic [1:0] out_slot;
  logic [7:0] out_duration, now;
  logic [3:0] occupied;

  logic       t3_tick = 1'b0, t3_enter_valid = 1'b0, t3_exit_valid = 1'b0;
  logic [1:0] t3_enter_slot = '0, t3_exit_slot = '0;
  logic       t3_out_valid, t3_out_overflow, t3_err_enter, t3_err_exit;
  logic [1:0] t3_out_slot;
  logic [7:0] t3_out_duration, t3_now;
  logic [2:0] t3_occupied;

  parking_duration_tracker dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .enter_valid(enter_valid), .enter_slot(enter_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .out_valid(out_valid), .out_slot(out_slot), .out_duration(out_duration),
    .out_overflow(out_overflow), .err_enter(err_enter), .err_exit(err_exit),
    .occupied(occupied), .now(now)
  );

  parking_duration_tracker #(.TIME_W(8), .SLOTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick(t3_tick),
    .enter_valid(t3_enter_valid), .enter_slot(t3_enter_slot),
    .exit_valid(t3_exit_valid), .exit_slot(t3_exit_slot),
    .out_valid(t3_out_valid), .out_slot(t3_out_slot), .out_duration(t3_out_duration),
    .out_overflow(t3_out_overflow), .err_enter(t3_err_enter), .err_exit(t3_err_exit),
    .occupied(t3_occupied), .now(t3_now)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: absolute tick count, per-slot absolute entry time, occupancy.
  longint     abs_t;
  longint     ent_m [4];
  bit   [3:0] occ_m;
  bit         exp_ov, exp_ee, exp_xe, exp_ovf;
  bit   [1:0] exp_slot;
  bit   [7:0] exp_dur;

  function automatic bit [7:0] model_now();
    longint m;
    m = abs_t % 256;
    return 8'(m);
  endfunction

  task automatic model_reset();
    abs_t = 0; occ_m = '0; exp_ov = 0; exp_ee = 0; exp_xe = 0;
    exp_ovf = 0; exp_slot = '0; exp_dur = '0;
    for (int i = 0; i < 4; i++) ent_m[i] = 0;
  endtask

  task automatic step(input bit t, input bit ev, input logic [1:0] es,
                      input bit xv, input logic [1:0] xs);
    longint el;
    tick = t; enter_valid = ev; enter_slot = es; exit_valid = xv; exit_slot = xs;
    exp_ov = 0; exp_ee = 0; exp_xe = 0;
    if (xv) begin
      if (occ_m[xs]) begin
        el = abs_t - ent_m[xs];
        exp_ov = 1; exp_slot = xs;
        exp_ovf = (el >= 256);
        exp_dur = exp_ovf ? 8'hFF : 8'(el);
        occ_m[xs] = 0;
      end else exp_xe = 1;
    end
    if (ev) begin
      if (!occ_m[es]) begin occ_m[es] = 1; ent_m[es] = abs_t; end
      else exp_ee = 1;
    end
    if (t) abs_t++;
    @(posedge clk); #1;
    tick = 0; enter_valid = 0; exit_valid = 0;
  endtask

  task automatic run_to(input int target);
    while (model_now() != 8'(target)) step(1, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick = 0; enter_valid = 0; exit_valid = 0;
    t3_tick = 0; t3_enter_valid = 0; t3_exit_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (now !== 8'd0) begin n_fail++; $display("FAIL reset_now: got %0d want 0", now); end
    n_cmp++; if (occupied !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %b want 0000", occupied); end
    n_cmp++; if ({out_valid, err_enter, err_exit, out_overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {out_valid, err_enter, err_exit, out_overflow}); end
    n_cmp++; if ({out_slot, out_duration} !== 10'd0) begin
      n_fail++; $display("FAIL reset_result: got slot %0d dur %0d want 0 0", out_slot, out_duration); end
  endtask

  task automatic test_basic_stay();
    do_reset();
    run_to(5);
    step(1, 1, 2'd1, 0, 2'd0);
    run_to(17);
    step(1, 0, 2'd0, 1, 2'd1);
    n_cmp++; if ({out_valid, out_slot, out_overflow} !== {1'b1, 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL basic_pulse: got v%b s%0d o%b want v1 s1 o0", out_valid, out_slot, out_overflow); end
    n_cmp++; if (out_duration !== 8'd12) begin n_fail++; $display("FAIL basic_dur: got %0d want 12", out_duration); end
    n_cmp++; if (occupied[1] !== 1'b0) begin n_fail++; $display("FAIL basic_occ: got %b want 0", occupied[1]); end
    step(1, 0, 2'd0, 0, 2'd0);
    n_cmp++; if (out_valid !== 1'b0 || out_duration !== 8'd12) begin
      n_fail++; $display("FAIL basic_hold: got v%b dur %0d want v0 dur 12", out_valid, out_duration); end
  endtask

  task automatic test_wrap();
    do_reset();
    run_to(250);
    step(1, 1, 2'd0, 0, 2'd0);
    run_to(4);
    step(1, 0, 2'd0, 1, 2'd0);
    n_cmp++; if ({out_valid, out_duration, out_overflow} !== {1'b1, 8'd10, 1'b0}) begin
      n_fail++; $display("FAIL wrap_dur: got v%b dur %0d o%b want v1 dur 10 o0", out_valid, out_duration, out_overflow); end
  endtask

  task automatic test_saturation();
    do_reset();
    run_to(3);
    step(1, 1, 2'd2, 0, 2'd0);
    step(1, 1, 2'd1, 0, 2'd0);
    step(1, 1, 2'd0, 0, 2'd0);
    while (abs_t != 259) step(1, 0, 2'd0, 0, 2'd0);
    step(1, 0, 2'd0, 1, 2'd1);
    n_cmp++; if ({out_duration, out_overflow} !== {8'd255, 1'b0}) begin
      n_fail++; $display("FAIL sat_255: got dur %0d o%b want 255 o0", out_duration, out_overflow); end
    step(1, 0, 2'd0, 0, 2'd0);
    step(1, 0, 2'd0, 1, 2'd0);
    n_cmp++; if ({out_valid, out_duration, out_overflow} !== {1'b1, 8'd255, 1'b1}) begin
      n_fail++; $display("FAIL sat_256: got v%b dur %0d o%b want v1 255 o1", out_valid, out_duration, out_overflow); end
    run_to(7);
    step(1, 0, 2'd0, 1, 2'd2);
    n_cmp++; if ({out_slot, out_duration, out_overflow} !== {2'd2, 8'd255, 1'b1}) begin
      n_fail++; $display("FAIL sat_slot2: got s%0d dur %0d o%b want s2 255 o1", out_slot, out_duration, out_overflow); end
  endtask

  task automatic test_errors();
    do_reset();
    run_to(8);
    step(1, 1, 2'd3, 0, 2'd0);
    run_to(12);
    step(1, 1, 2'd3, 0, 2'd0);
    n_cmp++; if ({err_enter, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL err_enter_dup: got ee%b v%b want ee1 v0", err_enter, out_valid); end
    step(1, 0, 2'd0, 1, 2'd0);
    n_cmp++; if ({err_exit, out_valid, err_enter} !== 3'b100) begin
      n_fail++; $display("FAIL err_exit_empty: got ex%b v%b ee%b want ex1 v0 ee0", err_exit, out_valid, err_enter); end
    run_to(20);
    step(1, 0, 2'd0, 1, 2'd3);
    n_cmp++; if ({out_valid, out_duration} !== {1'b1, 8'd12}) begin
      n_fail++; $display("FAIL err_stamp_kept: got v%b dur %0d want v1 12", out_valid, out_duration); end
    t3_exit_valid = 1; t3_exit_slot = 2'd3;
    @(posedge clk); #1; t3_exit_valid = 0;
    n_cmp++; if ({t3_err_exit, t3_out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL err3_exit_range: got ex%b v%b want ex1 v0", t3_err_exit, t3_out_valid); end
    t3_enter_valid = 1; t3_enter_slot = 2'd3;
    @(posedge clk); #1; t3_enter_valid = 0;
    n_cmp++; if ({t3_err_enter, t3_occupied} !== 4'b1000) begin
      n_fail++; $display("FAIL err3_enter_range: got ee%b occ %b want ee1 000", t3_err_enter, t3_occupied); end
    t3_enter_valid = 1; t3_enter_slot = 2'd2;
    @(posedge clk); #1; t3_enter_valid = 0;
    t3_exit_valid = 1; t3_exit_slot = 2'd2;
    @(posedge clk); #1; t3_exit_valid = 0;
    n_cmp++; if ({t3_out_valid, t3_out_slot, t3_out_duration, t3_occupied} !== {1'b1, 2'd2, 8'd0, 3'b000}) begin
      n_fail++; $display("FAIL err3_zero_stay: got v%b s%0d dur %0d occ %b want v1 s2 0 000",
                         t3_out_valid, t3_out_slot, t3_out_duration, t3_occupied); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_to(10);
    step(1, 1, 2'd1, 0, 2'd0);
    run_to(20);
    step(1, 1, 2'd1, 1, 2'd1);
    n_cmp++; if ({out_valid, out_duration, err_enter, occupied[1]} !== {1'b1, 8'd10, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL simul_same: got v%b dur %0d ee%b occ%b want v1 10 ee0 occ1",
                         out_valid, out_duration, err_enter, occupied[1]); end
    run_to(25);
    step(1, 0, 2'd0, 1, 2'd1);
    n_cmp++; if (out_duration !== 8'd5) begin n_fail++; $display("FAIL simul_restamp: got %0d want 5", out_duration); end
    step(1, 1, 2'd2, 1, 2'd2);
    n_cmp++; if ({err_exit, out_valid, err_enter, occupied[2]} !== 4'b1001) begin
      n_fail++; $display("FAIL simul_empty: got ex%b v%b ee%b occ%b want 1 0 0 1", err_exit, out_valid, err_enter, occupied[2]); end
    step(1, 1, 2'd0, 1, 2'd2);
    n_cmp++; if ({out_valid, out_slot, out_duration, occupied} !== {1'b1, 2'd2, 8'd1, 4'b0001}) begin
      n_fail++; $display("FAIL simul_diff: got v%b s%0d dur %0d occ %b want v1 s2 1 0001", out_valid, out_slot, out_duration, occupied); end
  endtask

  task automatic test_reset_mid_stay();
    do_reset();
    run_to(30);
    step(1, 1, 2'd0, 0, 2'd0);
    step(1, 1, 2'd2, 0, 2'd0);
    step(1, 0, 2'd0, 0, 2'd0);
    rst_n = 0;
    #1;
    n_cmp++; if ({occupied, now} !== 12'd0) begin
      n_fail++; $display("FAIL async_reset: got occ %b now %0d want 0000 0", occupied, now); end
    #2 rst_n = 1;
    model_reset();
    step(1, 0, 2'd0, 1, 2'd0);
    n_cmp++; if ({err_exit, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_discard: got ex%b v%b want ex1 v0", err_exit, out_valid); end
  endtask

  task automatic test_random();
    bit t, ev, xv;
    logic [1:0] es, xs;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      t  = ($urandom_range(0, 3) != 0);
      ev = ($urandom_range(0, 3) == 0);
      xv = (c < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      es = 2'($urandom_range(0, 3));
      xs = 2'($urandom_range(0, 3));
      step(t, ev, es, xv, xs);
      n_cmp++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, exp_ov); end
      n_cmp++; if ({out_slot, out_duration, out_overflow} !== {exp_slot, exp_dur, exp_ovf}) begin
        n_fail++; $display("FAIL rnd_result c%0d: got s%0d dur %0d o%b want s%0d dur %0d o%b",
                           c, out_slot, out_duration, out_overflow, exp_slot, exp_dur, exp_ovf); end
      n_cmp++; if ({err_enter, err_exit} !== {exp_ee, exp_xe}) begin
        n_fail++; $display("FAIL rnd_err c%0d: got ee%b ex%b want ee%b ex%b", c, err_enter, err_exit, exp_ee, exp_xe); end
      n_cmp++; if (occupied !== occ_m) begin n_fail++; $display("FAIL rnd_occ c%0d: got %b want %b", c, occupied, occ_m); end
      n_cmp++; if (now !== model_now()) begin n_fail++; $display("FAIL rnd_now c%0d: got %0d want %0d", c, now, model_now()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_stay();
    test_wrap();
    test_saturation();
    test_errors();
    test_simultaneous();
    test_reset_mid_stay();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
